// File: rtl/apb_pkg.sv
// Shared APB definitions: protection bit indices, completer FSM states and
// helpers mapping between an address's region field and the pprot it needs.
package apb_pkg;

  localparam int PROT_PRIV  = 0;
  localparam int PROT_NSEC  = 1;
  localparam int PROT_INSTR = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } completer_state_e;

  // pprot bits an access to addr must carry (region field starting at lsb)
  function automatic logic [2:0] getPprot(input logic [31:0] addr, input int lsb = 4);
    logic [31:0] sh;
    sh = addr >> lsb;
    return sh[2:0];
  endfunction

  // replace the region field of addr with pprot
  function automatic logic [31:0] getAddrforPprot(input logic [2:0] pprot,
                                                  input logic [31:0] addr,
                                                  input int lsb = 4);
    logic [31:0] msk;
    logic [31:0] fld;
    msk = 32'h7 << lsb;
    fld = {29'b0, pprot} << lsb;
    return (addr & ~msk) | fld;
  endfunction

endpackage

// File: rtl/apb_completer_mem.sv
// Word memory with byte-strobed write and a registered read port; the read
// register doubles as the completer's prdata and can be cleared on errors.
module apb_completer_mem #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  re,
  input  logic                  rclr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (wstrb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata <= '0;
    else if (rclr) rdata <= '0;
    else if (re)   rdata <= mem[idx];
  end

endmodule

// File: rtl/apb_completer.sv
// APB4 completer: setup latch, fixed wait-state counter, region/alignment/
// range checks and sticky protocol-error tracking in front of a word memory.
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 1,
  parameter int REGION_LSB  = 4
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam logic [3:0]            WAIT_C  = 4'(WAIT_CYCLES);

  completer_state_e state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  proto_q, proto_d, proto_now;
  logic                  start, done;

  logic                  wr_q, err_pre_q, err_pre_now, err_fin;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;

  // pprot is only consumed by the setup-time region check
  assign err_pre_now = (|paddr[1:0])
                     | (paddr[ADDR_WIDTH-1:2] >= DEPTH_W)
                     | (|(paddr[REGION_LSB+2:REGION_LSB] & ~pprot))
                     | (!pwrite && (|pstrb));

  // protocol error includes whatever is sampled on the completing edge
  assign proto_now = proto_q | ~psel | ~penable;
  assign err_fin   = err_pre_q | proto_now;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      proto_q <= proto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    proto_d = proto_q;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = '0;
          proto_d = 1'b0;
          start   = 1'b1;
        end
      end
      ACCESS: begin
        proto_d = proto_now;
        if (cnt_q < WAIT_C) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_q      <= 1'b0;
      err_pre_q <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
    end else begin
      if (start) begin
        wr_q      <= pwrite;
        err_pre_q <= err_pre_now;
        idx_q     <= paddr[IDX_W+1:2];
        wdata_q   <= pwdata;
        strb_q    <= pstrb;
      end
      pready  <= done;
      pslverr <= done & err_fin;
    end
  end

  apb_completer_mem #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .rst_n (presetn),
    .idx   (idx_q),
    .we    (done & wr_q & ~err_fin),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .re    (done & ~wr_q & ~err_fin),
    .rclr  (done & ~wr_q & err_fin),
    .rdata (prdata)
  );

endmodule

// File: tb/tb_apb_completer.sv
// Randomized and directed bench for apb_completer against a word-array model.
module tb_apb_completer;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [64];

  always #5 pclk = ~pclk;

  apb_completer dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  function automatic logic exp_err(input logic wr, input logic [31:0] a,
                                   input logic [2:0] pr, input logic [3:0] st);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 64) ||
           ((getPprot(a) & ~pr) != 3'b000) || (!wr && st != 4'h0);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // One transfer; returns data/err at pready and the number of access edges
  // (-1 if pready never came). drop releases psel right after setup.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] pr,
                      input logic [31:0] wd, input logic [3:0] st, input bit drop,
                      output logic [31:0] rd, output logic err, output int lat);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pprot = pr;
    pwdata = wd; pstrb = st;
    @(posedge pclk); #1;
    if (drop) psel = 1'b0; else penable = 1'b1;
    lat = -1; rd = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge pclk); #1;
      if (pready) begin
        lat = i; rd = prdata; err = pslverr;
        break;
      end
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic test_reset;
    presetn = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0;
    pprot = '0; pwdata = '0; pstrb = '0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    repeat (3) @(posedge pclk);
    #1;
    n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL reset_pready got %b want 0", pready); end
    n_cmp++; if (pslverr !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr got %b want 0", pslverr); end
    n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("FAIL reset_prdata got %h want 0", prdata); end
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_read_from_reset;
    logic [31:0] rd; logic err; int lat;
    xfer(0, 32'h04, getPprot(32'h04), '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd0_latency got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rd0_data got %h want 0", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd0_err got %b want 0", err); end
  endtask

  task automatic test_full_write;
    logic [31:0] rd; logic err; int lat;
    xfer(1, 32'h04, 3'b000, 32'hFFFF_FFFF, 4'hF, 0, rd, err, lat);
    model[1] = 32'hFFFF_FFFF;
    n_cmp++; if (err !== 1'b0 || lat !== 2) begin n_bad++; $display("FAIL wr_full err=%b lat=%0d want 0/2", err, lat); end
    xfer(0, 32'h04, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (err !== 1'b0 || rd !== model[1]) begin n_bad++; $display("FAIL rd_full got %h/%b want %h/0", rd, err, model[1]); end
  endtask

  task automatic test_sparse_write;
    logic [31:0] rd; logic err; int lat;
    xfer(0, 32'h84, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (rd !== 32'h0 || err !== 1'b0) begin n_bad++; $display("FAIL sparse_pre got %h/%b want 0/0", rd, err); end
    xfer(1, 32'h84, 3'b000, 32'hFFFF_FFFF, 4'h1, 0, rd, err, lat);
    model[33] = merge(model[33], 32'hFFFF_FFFF, 4'h1);
    xfer(0, 32'h84, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (rd !== 32'h0000_00FF || err !== 1'b0) begin n_bad++; $display("FAIL sparse_rd got %h/%b want 000000ff/0", rd, err); end
  endtask

  task automatic test_region;
    logic [31:0] rd; logic err; int lat; logic [31:0] a, v;
    logic [2:0] bad [3];
    bad[0] = 3'b110; bad[1] = 3'b101; bad[2] = 3'b011;
    a = getAddrforPprot(3'b111, 32'h04);
    n_cmp++; if (a !== 32'h74) begin n_bad++; $display("FAIL region_addr got %h want 74", a); end
    v = $urandom;
    xfer(1, a, 3'b111, v, 4'hF, 0, rd, err, lat);
    model[a >> 2] = v;
    xfer(0, a, 3'b111, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (rd !== v || err !== 1'b0) begin n_bad++; $display("FAIL region_ok got %h/%b want %h/0", rd, err, v); end
    for (int k = 0; k < 3; k++) begin
      xfer(0, a, bad[k], '0, 4'h0, 0, rd, err, lat);
      n_cmp++; if (rd !== 32'h0 || err !== 1'b1) begin n_bad++; $display("FAIL region_deny prot=%b got %h/%b want 0/1", bad[k], rd, err); end
    end
    xfer(1, a, 3'b110, ~v, 4'hF, 0, rd, err, lat);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL region_wr_err got %b want 1", err); end
    xfer(0, a, 3'b111, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (rd !== v) begin n_bad++; $display("FAIL region_wr_blocked got %h want %h", rd, v); end
  endtask

  task automatic test_proto;
    logic [31:0] rd; logic err; int lat; logic [31:0] v;
    xfer(0, 32'h03, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL unaligned got %b want 1", err); end
    xfer(0, 32'h100, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL range got %b want 1", err); end
    xfer(1, 32'h100, 3'b000, 32'h1234_5678, 4'hF, 0, rd, err, lat);
    xfer(0, 32'h000, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (rd !== model[0]) begin n_bad++; $display("FAIL range_wr_alias got %h want %h", rd, model[0]); end
    xfer(0, 32'h04, 3'b000, '0, 4'h2, 0, rd, err, lat);
    n_cmp++; if (err !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL rd_strb got %h/%b want 0/1", rd, err); end
    v = $urandom;
    xfer(1, 32'h08, 3'b000, v, 4'hF, 1, rd, err, lat);
    n_cmp++; if (lat !== 2 || err !== 1'b1) begin n_bad++; $display("FAIL psel_drop lat=%0d err=%b want 2/1", lat, err); end
    xfer(0, 32'h08, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (rd !== model[2] || err !== 1'b0) begin n_bad++; $display("FAIL psel_drop_mem got %h/%b want %h/0", rd, err, model[2]); end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, ed; logic err, wr, ee; logic [2:0] pr; logic [3:0] st; int lat;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom);
      a  = ($urandom % 8 == 0) ? 32'($urandom_range(0, 32'h11F)) : {24'h0, 6'($urandom), 2'b00};
      pr = 3'($urandom);
      d  = $urandom;
      st = wr ? 4'($urandom) : (($urandom % 6 == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
      ee = exp_err(wr, a, pr, st);
      ed = '0;
      if (!ee) begin
        if (wr) model[a >> 2] = merge(model[a >> 2], d, st);
        else    ed = model[a >> 2];
      end
      xfer(wr, a, pr, d, st, 0, rd, err, lat);
      n_cmp++;
      if (lat !== 2 || err !== ee || (!wr && rd !== ed)) begin
        n_bad++;
        $display("FAIL rand#%0d wr=%b a=%h prot=%b strb=%h got %h/%b/%0d want %h/%b/2",
                 n, wr, a, pr, st, rd, err, lat, ed, ee);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic err; int lat;
    xfer(1, 32'h08, 3'b000, 32'hA5A5_A5A5, 4'hF, 0, rd, err, lat);
    xfer(0, 32'h08, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (rd !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL pre_rst_rd got %h want a5a5a5a5", rd); end
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h08; pprot = 0; pstrb = 0;
    @(posedge pclk); #1; penable = 1;
    @(posedge pclk); #2;
    presetn = 1'b0; #1;
    n_cmp++; if (pready !== 1'b0 || prdata !== 32'h0) begin n_bad++; $display("FAIL mid_rst got %b/%h want 0/0", pready, prdata); end
    psel = 0; penable = 0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(0, 32'h08, 3'b000, '0, 4'h0, 0, rd, err, lat);
    n_cmp++; if (rd !== 32'h0 || err !== 1'b0 || lat !== 2) begin n_bad++; $display("FAIL post_rst_rd got %h/%b/%0d want 0/0/2", rd, err, lat); end
  endtask

  initial begin
    test_reset;
    test_read_from_reset;
    test_full_write;
    test_sparse_write;
    test_region;
    test_proto;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
